picorv32_ahb_bus_master: RTL and testbench

Consumes the single-transfer request bundle produced by picorv32_to_ahb_master_adapter and executes it as one AMBA AHB 2.0 NONSEQ SINGLE transfer on the GRLIB AHB bus. Handles arbitration (hbusreq/hgrant), address and data phases, wait states, and two-cycle OKAY-less responses (ERROR/RETRY/SPLIT). Returns read data and a one-cycle ready pulse to the adapter. Sits between the adapter and the AHB controller.

---
 rtl/picorv32_ahb_bus_master_pkg.sv | 59 +++++
 rtl/picorv32_ahb_bus_master_if.sv | 47 ++++
 rtl/picorv32_ahb_bus_master.sv | 142 ++++++++++++++
 tb/tb_picorv32_ahb_bus_master.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/picorv32_ahb_bus_master_pkg.sv
// Shared AHB encodings, widths, FSM states and request record for the AHB bus master.
package picorv32_ahb_bus_master_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned SIZE_W      = 3;
  localparam int unsigned PROT_W      = 4;
  localparam int unsigned TRANS_W     = 2;
  localparam int unsigned RESP_W      = 2;
  localparam int unsigned BURST_W     = 3;
  localparam int unsigned RETRY_CNT_W = 8;

  localparam logic [TRANS_W-1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [TRANS_W-1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [RESP_W-1:0] HRESP_OKAY  = 2'b00;
  localparam logic [RESP_W-1:0] HRESP_ERROR = 2'b01;
  localparam logic [RESP_W-1:0] HRESP_RETRY = 2'b10;
  localparam logic [RESP_W-1:0] HRESP_SPLIT = 2'b11;

  localparam logic [SIZE_W-1:0] HSIZE_BYTE = 3'b000;
  localparam logic [SIZE_W-1:0] HSIZE_HALF = 3'b001;
  localparam logic [SIZE_W-1:0] HSIZE_WORD = 3'b010;

  localparam logic [BURST_W-1:0] BURST_SINGLE = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Latched copy of the adapter request, replayed unchanged on every retry.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [SIZE_W-1:0] size;
    logic [PROT_W-1:0] prot;
    logic              lock;
    logic              write;
  } req_t;

  // Natural alignment of the request; sizes above a word are rejected.
  function automatic logic size_addr_ok(input logic [SIZE_W-1:0] size,
                                        input logic [1:0]        addr_lsb);
    logic ok;
    ok = 1'b0;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = ~addr_lsb[0];
      HSIZE_WORD: ok = (addr_lsb == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/picorv32_ahb_bus_master_if.sv
// Adapter request/response bundle plus the AHB master-side signals.
interface picorv32_ahb_bus_master_if;
  import picorv32_ahb_bus_master_pkg::*;

  logic                mem_ahb_valid;
  logic                mem_ahb_write;
  logic                mem_ahb_read;
  logic [ADDR_W-1:0]   mem_ahb_addr;
  logic [DATA_W-1:0]   mem_ahb_wdata;
  logic [SIZE_W-1:0]   mem_ahb_size;
  logic [PROT_W-1:0]   mem_ahb_prot;
  logic                mem_ahb_lock;
  logic                mem_ahb_ready;
  logic [DATA_W-1:0]   mem_ahb_rdata;
  logic                mem_ahb_err;

  logic                hbusreq;
  logic                hlock;
  logic                hgrant;
  logic                hready;
  logic [RESP_W-1:0]   hresp;
  logic [DATA_W-1:0]   hrdata;
  logic [TRANS_W-1:0]  htrans;
  logic [ADDR_W-1:0]   haddr;
  logic                hwrite;
  logic [SIZE_W-1:0]   hsize;
  logic [BURST_W-1:0]  hburst;
  logic [PROT_W-1:0]   hprot;
  logic [DATA_W-1:0]   hwdata;

  modport master (
    input  mem_ahb_valid, mem_ahb_write, mem_ahb_read, mem_ahb_addr, mem_ahb_wdata,
           mem_ahb_size, mem_ahb_prot, mem_ahb_lock,
    output mem_ahb_ready, mem_ahb_rdata, mem_ahb_err,
    output hbusreq, hlock, htrans, haddr, hwrite, hsize, hburst, hprot, hwdata,
    input  hgrant, hready, hresp, hrdata
  );

  modport slave (
    output mem_ahb_valid, mem_ahb_write, mem_ahb_read, mem_ahb_addr, mem_ahb_wdata,
           mem_ahb_size, mem_ahb_prot, mem_ahb_lock,
    input  mem_ahb_ready, mem_ahb_rdata, mem_ahb_err,
    input  hbusreq, hlock, htrans, haddr, hwrite, hsize, hburst, hprot, hwdata,
    output hgrant, hready, hresp, hrdata
  );

endinterface

// File: rtl/picorv32_ahb_bus_master.sv
// Executes one adapter request as an AHB NONSEQ SINGLE transfer with arbitration,
// wait states, ERROR termination and bounded/unbounded RETRY/SPLIT re-issue.
module picorv32_ahb_bus_master
  import picorv32_ahb_bus_master_pkg::*;
#(
  parameter int unsigned         RETRY_LIMIT   = 0,
  parameter logic [BURST_W-1:0]  HBURST_SINGLE = BURST_SINGLE
) (
  input  logic                        clk,
  input  logic                        resetn,
  picorv32_ahb_bus_master_if.master   bus
);

  state_e                  state;
  req_t                    lat;
  logic [RETRY_CNT_W-1:0]  retry_cnt;
  logic [RETRY_CNT_W-1:0]  retry_nxt;
  logic                    retry_exhausted;

  // Retry bookkeeping: a zero limit means re-issue forever.
  assign retry_nxt       = retry_cnt + RETRY_CNT_W'(1);
  assign retry_exhausted = (RETRY_LIMIT != 0) && (32'(retry_nxt) == RETRY_LIMIT);

  assign bus.hburst = HBURST_SINGLE;

  // Transfer FSM with registered bus and completion outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state             <= ST_IDLE;
      lat               <= '0;
      retry_cnt         <= '0;
      bus.mem_ahb_ready <= 1'b0;
      bus.mem_ahb_err   <= 1'b0;
      bus.mem_ahb_rdata <= '0;
      bus.hbusreq       <= 1'b0;
      bus.hlock         <= 1'b0;
      bus.htrans        <= HTRANS_IDLE;
      bus.haddr         <= '0;
      bus.hwrite        <= 1'b0;
      bus.hsize         <= '0;
      bus.hprot         <= '0;
      bus.hwdata        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.mem_ahb_valid) begin
            lat.addr  <= bus.mem_ahb_addr;
            lat.wdata <= bus.mem_ahb_wdata;
            lat.size  <= bus.mem_ahb_size;
            lat.prot  <= bus.mem_ahb_prot;
            lat.lock  <= bus.mem_ahb_lock;
            lat.write <= bus.mem_ahb_write;
            if ((bus.mem_ahb_write ^ bus.mem_ahb_read) &&
                size_addr_ok(bus.mem_ahb_size, bus.mem_ahb_addr[1:0])) begin
              state       <= ST_REQ;
              bus.hbusreq <= 1'b1;
              bus.hlock   <= bus.mem_ahb_lock;
            end else begin
              state             <= ST_DONE;
              bus.mem_ahb_ready <= 1'b1;
              bus.mem_ahb_err   <= 1'b1;
              bus.mem_ahb_rdata <= '0;
            end
          end
        end

        ST_REQ: begin
          if (bus.hgrant && bus.hready) begin
            state       <= ST_ADDR;
            bus.htrans  <= HTRANS_NONSEQ;
            bus.haddr   <= lat.addr;
            bus.hwrite  <= lat.write;
            bus.hsize   <= lat.size;
            bus.hprot   <= lat.prot;
            bus.hbusreq <= lat.lock;
          end
        end

        ST_ADDR: begin
          if (bus.hready) begin
            bus.htrans <= HTRANS_IDLE;
            if (bus.hgrant) begin
              state       <= ST_DATA;
              bus.hwdata  <= lat.wdata;
              bus.hbusreq <= 1'b0;
            end else begin
              state       <= ST_REQ;
              bus.hbusreq <= 1'b1;
            end
          end
        end

        ST_DATA: begin
          if (bus.hready) begin
            state             <= ST_DONE;
            bus.mem_ahb_ready <= 1'b1;
            bus.mem_ahb_err   <= (bus.hresp != HRESP_OKAY);
            bus.mem_ahb_rdata <= ((bus.hresp == HRESP_OKAY) && !lat.write) ? bus.hrdata : '0;
            bus.hbusreq       <= 1'b0;
            bus.hlock         <= 1'b0;
          end else begin
            case (bus.hresp)
              HRESP_ERROR: begin
                state             <= ST_DONE;
                bus.mem_ahb_ready <= 1'b1;
                bus.mem_ahb_err   <= 1'b1;
                bus.mem_ahb_rdata <= '0;
                bus.hbusreq       <= 1'b0;
                bus.hlock         <= 1'b0;
              end
              HRESP_RETRY, HRESP_SPLIT: begin
                retry_cnt <= retry_nxt;
                if (retry_exhausted) begin
                  state             <= ST_DONE;
                  bus.mem_ahb_ready <= 1'b1;
                  bus.mem_ahb_err   <= 1'b1;
                  bus.mem_ahb_rdata <= '0;
                  bus.hbusreq       <= 1'b0;
                  bus.hlock         <= 1'b0;
                end else begin
                  state       <= ST_REQ;
                  bus.hbusreq <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end

        ST_DONE: begin
          state             <= ST_IDLE;
          bus.mem_ahb_ready <= 1'b0;
          bus.mem_ahb_err   <= 1'b0;
          retry_cnt         <= '0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picorv32_ahb_bus_master.sv
// Bench for the AHB bus master: vector table, hand sequences and randomized model check.
module tb_picorv32_ahb_bus_master;

  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] R_OKAY = 2'b00, R_ERROR = 2'b01, R_RETRY = 2'b10;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        sel, valid, wr, rd, lock, hgrant, hready;
  logic [31:0] addr, wdata, hrdata;
  logic [2:0]  size;
  logic [3:0]  prot;
  logic [1:0]  hresp;

  picorv32_ahb_bus_master_if if0();
  picorv32_ahb_bus_master_if if2();

  assign if0.mem_ahb_valid = valid & ~sel;
  assign if2.mem_ahb_valid = valid & sel;
  assign if0.mem_ahb_write = wr;    assign if2.mem_ahb_write = wr;
  assign if0.mem_ahb_read  = rd;    assign if2.mem_ahb_read  = rd;
  assign if0.mem_ahb_addr  = addr;  assign if2.mem_ahb_addr  = addr;
  assign if0.mem_ahb_wdata = wdata; assign if2.mem_ahb_wdata = wdata;
  assign if0.mem_ahb_size  = size;  assign if2.mem_ahb_size  = size;
  assign if0.mem_ahb_prot  = prot;  assign if2.mem_ahb_prot  = prot;
  assign if0.mem_ahb_lock  = lock;  assign if2.mem_ahb_lock  = lock;
  assign if0.hgrant = hgrant;       assign if2.hgrant = hgrant;
  assign if0.hready = hready;       assign if2.hready = hready;
  assign if0.hresp  = hresp;        assign if2.hresp  = hresp;
  assign if0.hrdata = hrdata;       assign if2.hrdata = hrdata;

  picorv32_ahb_bus_master #(.RETRY_LIMIT(0), .HBURST_SINGLE(3'b000)) u_dut0 (
    .clk(clk), .resetn(resetn), .bus(if0));
  picorv32_ahb_bus_master #(.RETRY_LIMIT(2), .HBURST_SINGLE(3'b000)) u_dut2 (
    .clk(clk), .resetn(resetn), .bus(if2));

  // Outputs of whichever instance is currently selected.
  logic        o_ready, o_err, o_hbusreq, o_hlock, o_hwrite;
  logic [31:0] o_rdata, o_haddr, o_hwdata;
  logic [1:0]  o_htrans;
  logic [2:0]  o_hsize, o_hburst;
  logic [3:0]  o_hprot;
  always_comb begin
    if (sel) begin
      o_ready = if2.mem_ahb_ready; o_err = if2.mem_ahb_err; o_rdata = if2.mem_ahb_rdata;
      o_hbusreq = if2.hbusreq; o_hlock = if2.hlock; o_hwrite = if2.hwrite;
      o_haddr = if2.haddr; o_hwdata = if2.hwdata; o_htrans = if2.htrans;
      o_hsize = if2.hsize; o_hburst = if2.hburst; o_hprot = if2.hprot;
    end else begin
      o_ready = if0.mem_ahb_ready; o_err = if0.mem_ahb_err; o_rdata = if0.mem_ahb_rdata;
      o_hbusreq = if0.hbusreq; o_hlock = if0.hlock; o_hwrite = if0.hwrite;
      o_haddr = if0.haddr; o_hwdata = if0.hwdata; o_htrans = if0.htrans;
      o_hsize = if0.hsize; o_hburst = if0.hburst; o_hprot = if0.hprot;
    end
  end

  typedef struct {
    bit          sel;
    bit          wr, rd, lock, ferr;
    logic [31:0] addr, wdata, rval;
    logic [2:0]  size;
    logic [3:0]  prot;
    int          gdelay, waits, nretry;
    bit          e_err;
    int          e_nonseq;
    logic [31:0] e_rdata;
    int          e_lat;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [2:0] sched[$];

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit s, bit w, bit r, logic [31:0] a, logic [2:0] sz, bit lk,
                              logic [31:0] wd, logic [31:0] rv, int gd, int ws, int nr, bit fe,
                              bit ee, int ens, logic [31:0] erd, int elat);
    vec_t v;
    v.sel = s; v.wr = w; v.rd = r; v.addr = a; v.size = sz; v.lock = lk; v.wdata = wd;
    v.rval = rv; v.gdelay = gd; v.waits = ws; v.nretry = nr; v.ferr = fe; v.prot = 4'h3;
    v.e_err = ee; v.e_nonseq = ens; v.e_rdata = erd; v.e_lat = elat;
    return v;
  endfunction

  // Expected outcome from the request/response rules, independent of any cycle detail
  // except the per-phase cycle counts (REQ 1, ADDR 1, DATA waits+1, DONE 1).
  function automatic vec_t model(input vec_t v);
    vec_t m;
    bit   bad;
    int   lim, att;
    m = v;
    bad = (v.wr == v.rd) || (v.size > 3'd2) || ((v.addr % (32'd1 << v.size)) != 0);
    if (bad) begin
      m.e_err = 1'b1; m.e_nonseq = 0; m.e_rdata = '0; m.e_lat = 1;
    end else begin
      lim = v.sel ? 2 : 0;
      if (lim != 0 && v.nretry >= lim) begin
        att = lim; m.e_err = 1'b1;
      end else begin
        att = v.nretry + 1; m.e_err = v.ferr;
      end
      m.e_nonseq = att;
      m.e_rdata  = (!m.e_err && v.rd) ? v.rval : 32'h0;
      m.e_lat    = v.gdelay + 1 + att * (v.waits + 2) + (att - 1) + 1;
    end
    return m;
  endfunction

  // Drives one request and plays the AHB slave/arbiter from the vector's script.
  task automatic run_txn(input vec_t v, output bit r_err, output logic [31:0] r_rdata,
                         output int r_nonseq, output int r_lat);
    int grant_left, retries_left, data_left, cyc;
    sched.delete();
    sel = v.sel; wr = v.wr; rd = v.rd; addr = v.addr; size = v.size; prot = v.prot;
    lock = v.lock; wdata = v.wdata; hrdata = v.rval; valid = 1'b1;
    hgrant = (v.gdelay == 0); hready = 1'b1; hresp = R_OKAY;
    grant_left = v.gdelay; retries_left = v.nretry; data_left = 0;
    r_nonseq = 0; r_lat = -1; r_err = 1'b0; r_rdata = '0; cyc = 0;
    while (cyc < 300 && r_lat < 0) begin
      @(posedge clk); @(negedge clk); cyc++;
      if (o_ready) begin
        r_lat = cyc; r_err = o_err; r_rdata = o_rdata;
      end else begin
        if (data_left > 0) begin
          if (v.wr) chk_eq("hwdata_hold", o_hwdata, v.wdata);
          chk_eq("hlock_data", 32'(o_hlock), 32'(v.lock));
          data_left--;
        end
        if (o_htrans == T_NONSEQ) begin
          r_nonseq++;
          if (r_nonseq == 1) chk_eq("nonseq_cycle", cyc, v.gdelay + 2);
          chk_eq("haddr", o_haddr, v.addr);
          chk_eq("hctl", {o_hwrite, o_hsize, o_hprot, o_hlock}, {v.wr, v.size, v.prot, v.lock});
          chk_eq("hbusreq_addr", 32'(o_hbusreq), 32'(v.lock));
          hgrant = 1'b1; hready = 1'b1; hresp = R_OKAY;
          data_left = v.waits + 1;
          for (int i = 0; i < v.waits; i++) sched.push_back({1'b0, R_OKAY});
          if (retries_left > 0) begin
            retries_left--;
            sched.push_back({1'b0, R_RETRY}); sched.push_back({1'b1, R_RETRY});
          end else if (v.ferr) begin
            sched.push_back({1'b0, R_ERROR}); sched.push_back({1'b1, R_ERROR});
          end else begin
            sched.push_back({1'b1, R_OKAY});
          end
        end else begin
          if (sched.size() > 0) {hready, hresp} = sched.pop_front();
          else begin hready = 1'b1; hresp = R_OKAY; end
          if (o_hbusreq && grant_left > 0) begin
            chk_eq("hlock_wait", 32'(o_hlock), 32'(v.lock));
            grant_left--; hgrant = 1'b0;
          end else hgrant = 1'b1;
        end
      end
    end
    if (r_lat < 0) begin
      checks++; failures++;
      $display("FAIL timeout: no ready within %0d cycles, required one", cyc);
    end
    // Valid stays high through the DONE cycle, as the adapter would leave it.
    @(posedge clk); @(negedge clk);
    chk_eq("ready_once_no_retrigger", {30'h0, o_ready, o_hbusreq}, 32'h0);
    valid = 1'b0; hgrant = 1'b1; hready = 1'b1; hresp = R_OKAY;
    sched.delete();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic run_and_check(input vec_t v, input string tag);
    bit e; logic [31:0] rdv; int ns, lt;
    run_txn(v, e, rdv, ns, lt);
    chk_eq({tag, "_err"}, 32'(e), 32'(v.e_err));
    chk_eq({tag, "_rdata"}, rdv, v.e_rdata);
    chk_eq({tag, "_nonseq"}, ns, v.e_nonseq);
    chk_eq({tag, "_latency"}, lt, v.e_lat);
  endtask

  vec_t tbl[13];

  initial begin
    int rcnt;
    vec_t v;
    sel = 0; valid = 0; wr = 0; rd = 0; lock = 0; addr = '0; wdata = '0; size = '0; prot = '0;
    hgrant = 1; hready = 1; hresp = R_OKAY; hrdata = '0;

    //      sel w r addr          sz lk wdata        rval         gd ws nr fe  err ns rdata        lat
    tbl[0]  = mk(0, 0, 1, 32'h4000_0000, 2, 0, 32'h0,       32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 4);
    tbl[1]  = mk(0, 1, 0, 32'h4000_0003, 0, 0, 32'h0000_00A5, 32'h1111_1111, 0, 2, 0, 0, 0, 1, 32'h0, 6);
    tbl[2]  = mk(0, 1, 0, 32'h4000_0002, 2, 0, 32'h1234_5678, 32'h0,       0, 0, 0, 0, 1, 0, 32'h0, 1);
    tbl[3]  = mk(0, 0, 1, 32'h4000_0001, 1, 0, 32'h0,       32'hFFFF_FFFF, 0, 0, 0, 0, 1, 0, 32'h0, 1);
    tbl[4]  = mk(0, 0, 1, 32'h4000_0002, 1, 0, 32'h0,       32'h1234_ABCD, 0, 1, 0, 0, 0, 1, 32'h1234_ABCD, 5);
    tbl[5]  = mk(0, 1, 1, 32'h4000_0000, 2, 0, 32'h0,       32'h5555_5555, 0, 0, 0, 0, 1, 0, 32'h0, 1);
    tbl[6]  = mk(0, 0, 0, 32'h4000_0000, 2, 0, 32'h0,       32'h5555_5555, 0, 0, 0, 0, 1, 0, 32'h0, 1);
    tbl[7]  = mk(0, 0, 1, 32'h4000_0000, 3, 0, 32'h0,       32'h5555_5555, 0, 0, 0, 0, 1, 0, 32'h0, 1);
    tbl[8]  = mk(0, 0, 1, 32'h4000_0008, 2, 0, 32'h0,       32'hCAFE_F00D, 0, 0, 0, 1, 1, 1, 32'h0, 4);
    tbl[9]  = mk(0, 0, 1, 32'h4000_0020, 2, 0, 32'h0,       32'h0BAD_F00D, 0, 0, 2, 0, 0, 3, 32'h0BAD_F00D, 10);
    tbl[10] = mk(1, 0, 1, 32'h4000_0020, 2, 0, 32'h0,       32'h0BAD_F00D, 0, 0, 2, 0, 1, 2, 32'h0, 7);
    tbl[11] = mk(0, 0, 1, 32'h4000_0040, 2, 1, 32'h0,       32'h7777_7777, 5, 0, 0, 1, 1, 1, 32'h0, 9);
    tbl[12] = mk(0, 1, 0, 32'h4000_0102, 1, 0, 32'h0000_BEEF, 32'h0,      0, 0, 0, 0, 0, 1, 32'h0, 4);

    // Reset state
    resetn = 1'b0;
    @(negedge clk); @(negedge clk);
    chk_eq("reset_ctl", {o_htrans, o_hbusreq, o_hlock, o_hwrite, o_hsize, o_hprot, o_hburst},
           32'h0);
    chk_eq("reset_haddr", o_haddr, 32'h0);
    chk_eq("reset_hwdata", o_hwdata, 32'h0);
    chk_eq("reset_resp", {o_ready, o_err, 30'h0} | o_rdata, 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_and_check(tbl[i], $sformatf("vec%0d", i));

    // Reset asserted while a read sits in its data phase
    sel = 0; wr = 0; rd = 1; addr = 32'h4000_0010; size = 3'd2; prot = 4'h1; lock = 1;
    wdata = 32'h0; hrdata = 32'h55AA_55AA; hgrant = 1; hready = 1; hresp = R_OKAY; valid = 1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk_eq("rst_seq_nonseq", 32'(o_htrans), 32'(T_NONSEQ));
    @(posedge clk); @(negedge clk);
    hready = 1'b0;
    @(posedge clk); @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk_eq("midreset_ctl", {o_htrans, o_hbusreq, o_hlock, o_hwrite, o_hsize, o_hprot}, 32'h0);
    chk_eq("midreset_haddr", o_haddr, 32'h0);
    chk_eq("midreset_hwdata", o_hwdata, 32'h0);
    chk_eq("midreset_resp", {o_ready, o_err, 30'h0} | o_rdata, 32'h0);
    valid = 1'b0; hready = 1'b1; lock = 0;
    @(negedge clk);
    resetn = 1'b1;
    rcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      if (o_ready) rcnt++;
    end
    chk_eq("midreset_no_ready", rcnt, 0);
    run_and_check(mk(0, 0, 1, 32'h4000_0010, 2, 0, 32'h0, 32'h600D_600D, 0, 0, 0, 0,
                     0, 1, 32'h600D_600D, 4), "post_reset");

    // Randomized requests against the behavioural model
    for (int n = 0; n < 60; n++) begin
      v.sel = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0: begin v.wr = 1; v.rd = 1; end
        1: begin v.wr = 0; v.rd = 0; end
        default: begin v.wr = $urandom_range(0, 1); v.rd = ~v.wr; end
      endcase
      v.size   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      v.addr   = $urandom;
      if ($urandom_range(0, 2) != 0) v.addr = v.addr & ~((32'd1 << v.size[1:0]) - 32'd1);
      v.prot   = 4'($urandom);
      v.lock   = $urandom_range(0, 1);
      v.wdata  = $urandom;
      v.rval   = $urandom;
      v.gdelay = $urandom_range(0, 3);
      v.waits  = $urandom_range(0, 3);
      v.nretry = $urandom_range(0, 3);
      v.ferr   = ($urandom_range(0, 7) == 0);
      v = model(v);
      run_and_check(v, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
